serial_frame_tx_queue: RTL
==========================

Name: serial_frame_tx_queue

Overview:
Buffered transmitter for the two-wire serial link (serialClock + serialData) consumed by receiveFrame. Accepts words over a valid/ready interface into a small FIFO and serializes each word as one frame: an 8-bit start-frame delimiter followed by the data word, both MSB first. Frames are sent back-to-back or separated by a programmable idle gap. Sits between a producer (sensor/packetizer logic) and the board-level serial pins.

Parameters:
WIDTH, 16, data bits per frame
DEPTH, 4, FIFO entries; power of 2, >= 2
HIGH_CYCLES, 8, clock cycles serialClock is high per bit
LOW_CYCLES, 8, clock cycles serialClock is low per bit
SFD, 8'hAB, start-frame delimiter value
SFD_BITS, 8, delimiter width
GAP_CYCLES, 0, idle cycles (both lines low) inserted between consecutive frames

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
in_data  in  WIDTH  word to transmit
in_valid  in  1  producer offers in_data
in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready at posedge
serialClock  out  1  serial bit clock, registered
serialData  out  1  serial data, registered; 0 whenever serialClock is 0
busy  out  1  FIFO non-empty or FSM not IDLE
level  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values: in_ready=0 while reset is high, 1 on the first cycle after reset; serialClock=0, serialData=0, busy=0, level=0, FSM=IDLE. Reset mid-frame aborts the frame: both serial lines are 0 on the cycle after the reset edge; FIFO contents are discarded.
- FIFO: in_ready = (level != DEPTH). Push and pop on the same edge leave level unchanged. No push while full. Read/write pointers wrap modulo DEPTH.
- FSM states: IDLE, BIT, GAP.
- IDLE: when the FIFO is non-empty at an edge, pop, load shift register {SFD, word} (SFD_BITS+WIDTH bits), clear the bit counter and phase counter, and go to BIT.
- BIT: phase counter runs 0..HIGH_CYCLES+LOW_CYCLES-1. serialClock=1 for phases 0..HIGH_CYCLES-1, else 0. serialData = current MSB of the shift register during the high phase, else 0. At the last phase, shift left one bit. After the last bit:
  - GAP_CYCLES>0: go to GAP.
  - GAP_CYCLES=0, FIFO non-empty: pop and reload on the same edge; the next frame's first high cycle immediately follows the previous low phase.
  - Otherwise: go to IDLE.
- GAP: both lines 0 for exactly GAP_CYCLES cycles, then the same decision as IDLE.
- Latency: word accepted at edge N with FSM IDLE and FIFO empty -> load at edge N+1 -> serialClock=1 in the cycle following edge N+1.
- Frame duration: (SFD_BITS+WIDTH)*(HIGH_CYCLES+LOW_CYCLES) cycles; default 384.
- busy deasserts on the cycle after the final low phase when nothing is queued.
- Counters are sized from the parameters (phase counter >= $clog2(HIGH_CYCLES+LOW_CYCLES) bits, bit counter >= $clog2(SFD_BITS+WIDTH+1) bits). No wrap is possible within a frame.

Test Plan:
- Single word: push 16'h1234 after reset, defaults. Serial clock high phases must carry 1,0,1,0,1,0,1,1 then 0001 0010 0011 0100. Each high phase is 8 cycles, each low phase is 8 cycles. First high cycle comes 2 edges after the accept; busy stays high for 384 cycles after the load.
- Back-to-back: push 16'hA5A5, 16'h0001, 16'hFFFF on consecutive cycles, GAP_CYCLES=0. The line shows three contiguous frames totalling 1152 cycles with no idle cycle between them. A loopback receiveFrame outputs the three words in order.
- Backpressure: hold in_valid with 6 distinct words, DEPTH=4. The first is popped immediately and in_ready falls after the 5th accept. The 6th word is accepted on the edge of the second pop, 384 cycles after the first load. level never exceeds 4, and all 6 words are received in order.
- Gap: GAP_CYCLES=20, two words queued. Exactly 20 cycles with serialClock=serialData=0 separate the last low phase of frame 1 from the first high phase of frame 2.
- Reset mid-frame: assert reset for 1 cycle during bit 10 of a frame with 2 words queued. The next cycle shows serialClock=0, level=0, busy=0, and in_ready=1 after reset. A new word 16'h00FF then yields a complete fresh frame, and a loopback receiver outputs only 16'h00FF.

Source files
------------

// File: rtl/serial_frame_tx_queue.sv
// serial_frame_tx_queue
// Buffered two-wire serial transmitter. Words arrive over valid/ready into a
// small FIFO. Each word goes out as one frame: an SFD_BITS delimiter followed
// by the WIDTH-bit word, both MSB first. Every bit is HIGH_CYCLES of
// serialClock high (data valid) then LOW_CYCLES low (data forced to 0).
// Consecutive frames are contiguous, or separated by GAP_CYCLES idle cycles.
//
// Ports:
//   clock       system clock, posedge
//   reset       synchronous, active-high
//   in_data     word to transmit
//   in_valid    producer offers in_data
//   in_ready    FIFO has room (low while reset is high)
//   serialClock registered serial bit clock
//   serialData  registered serial data, 0 whenever serialClock is 0
//   busy        FIFO non-empty or a frame/gap in progress
//   level       current FIFO occupancy
module serial_frame_tx_queue #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned HIGH_CYCLES = 8,
  parameter int unsigned LOW_CYCLES  = 8,
  parameter int unsigned SFD_BITS    = 8,
  parameter logic [SFD_BITS-1:0] SFD = 8'hAB,
  parameter int unsigned GAP_CYCLES  = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         serialClock,
  output logic                         serialData,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned BitCycles = HIGH_CYCLES + LOW_CYCLES;
  localparam int unsigned FrameBits = SFD_BITS + WIDTH;
  localparam int unsigned PhW       = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam int unsigned BitW      = $clog2(FrameBits + 1);
  localparam int unsigned PtrW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned GapW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned LvlW      = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StBit, StGap} state_e;

  state_e                 state_q, state_d;
  logic [PhW-1:0]         phase_q, phase_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic [FrameBits-1:0]   shift_q, shift_d;
  logic                   sclk_q, sclk_d;
  logic                   sdata_q, sdata_d;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]        count_q, count_d;

  logic push, pop, fifo_ne, want_load;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign fifo_ne  = (count_q != '0);
  assign in_ready = !reset && (count_q != LvlW'(DEPTH));
  assign push     = in_valid && in_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      // DEPTH is a power of 2, so the natural pointer overflow is the wrap.
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + LvlW'(push) - LvlW'(pop);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    gap_d     = gap_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    want_load = 1'b0;

    unique case (state_q)
      StIdle: want_load = 1'b1;
      StBit: begin
        if (phase_q == PhW'(BitCycles - 1)) begin
          phase_d = '0;
          shift_d = {shift_q[FrameBits-2:0], 1'b0};
          bit_d   = bit_q + BitW'(1);
          if (bit_q == BitW'(FrameBits - 1)) begin
            if (GAP_CYCLES > 0) begin
              state_d = StGap;
              gap_d   = '0;
            end else begin
              want_load = 1'b1;
            end
          end
        end else begin
          phase_d = phase_q + PhW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) begin
          want_load = 1'b1;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Shared by IDLE, end of frame (no gap) and end of gap: start the next
    // frame on this edge if a word is waiting, otherwise rest in IDLE.
    if (want_load) begin
      if (fifo_ne) begin
        pop     = 1'b1;
        shift_d = {SFD, mem_q[rd_ptr_q]};
        phase_d = '0;
        bit_d   = '0;
        state_d = StBit;
      end else begin
        state_d = StIdle;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: the line registers are fed from next-state values so the
  // first high cycle appears right after the load edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    sclk_d  = (state_d == StBit) && (phase_d < PhW'(HIGH_CYCLES));
    sdata_d = sclk_d && shift_d[FrameBits-1];
  end

  assign serialClock = sclk_q;
  assign serialData  = sdata_q;
  assign busy        = fifo_ne || (state_q != StIdle);
  assign level       = count_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      shift_q  <= '0;
      sclk_q   <= 1'b0;
      sdata_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shift_q  <= shift_d;
      sclk_q   <= sclk_d;
      sdata_q  <= sdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
